// File: rtl/commit_trace_fifo.sv
// commit_trace_fifo
// Passive capture of the CPU commit stream into a show-ahead FIFO. The FIFO
// drains to a host/trace port over valid/ready. Alongside it the block keeps
// a retire counter, a saturating drop counter and a sticky overflow flag.
// It never back-pressures the core: a commit that finds the FIFO full is
// dropped.
//
// Optional build macro: COMMIT_FLOW_CHECK_EN
//   defined   - a control-flow continuity checker is built. It compares each
//               commit pc with the previous commit's next pc and drives
//               flow_err / err_pc.
//   undefined - the checker is omitted, and flow_err / err_pc are tied to 0.
module commit_trace_fifo #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     commit,
  input  logic [63:0]              commit_pc,
  input  logic [63:0]              commit_pre_pc,
  input  logic [31:0]              commit_instr,
  output logic                     trace_valid,
  input  logic                     trace_ready,
  output logic [63:0]              trace_pc,
  output logic [63:0]              trace_pre_pc,
  output logic [31:0]              trace_instr,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [CNT_W-1:0]         drop_cnt,
  output logic [CNT_W-1:0]         retire_cnt,
  output logic                     flow_err,
  output logic [63:0]              err_pc
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [63:0]      pcMem    [DEPTH];
  logic [63:0]      prePcMem [DEPTH];
  logic [31:0]      instrMem [DEPTH];

  logic [PW-1:0]    wrPtr;
  logic [PW-1:0]    rdPtr;
  logic [LW-1:0]    levelQ;
  logic             overflowQ;
  logic [CNT_W-1:0] dropCntQ;
  logic [CNT_W-1:0] retireCntQ;

  logic             isEmpty;
  logic             isFull;
  logic             popOk;
  logic             pushOk;
  logic             dropEv;

  // Level is the only full/empty discriminator. The pointers wrap freely.
  assign isEmpty = (levelQ == '0);
  assign isFull  = (levelQ == FULL_LVL);

  // A pop is legal only from a non-empty FIFO. A full FIFO still accepts a
  // push when it pops in the same cycle. clr suppresses both.
  assign popOk  = !clr && !isEmpty && trace_ready;
  assign pushOk = !clr && commit && (!isFull || popOk);
  assign dropEv = !clr && commit && isFull && !popOk;

  // Entry storage. The head is masked while empty, so it needs no reset.
  always_ff @(posedge clk) begin
    if (pushOk) begin
      pcMem[wrPtr]    <= commit_pc;
      prePcMem[wrPtr] <= commit_pre_pc;
      instrMem[wrPtr] <= commit_instr;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr  <= '0;
      rdPtr  <= '0;
      levelQ <= '0;
    end else if (clr) begin
      wrPtr  <= '0;
      rdPtr  <= '0;
      levelQ <= '0;
    end else begin
      if (pushOk) begin
        wrPtr <= wrPtr + 1'b1;
      end
      if (popOk) begin
        rdPtr <= rdPtr + 1'b1;
      end
      case ({pushOk, popOk})
        2'b10:   levelQ <= levelQ + 1'b1;
        2'b01:   levelQ <= levelQ - 1'b1;
        default: levelQ <= levelQ;
      endcase
    end
  end

  // Statistics. The retire count wraps. The drop count saturates at all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflowQ  <= 1'b0;
      dropCntQ   <= '0;
      retireCntQ <= '0;
    end else if (clr) begin
      overflowQ  <= 1'b0;
      dropCntQ   <= '0;
      retireCntQ <= '0;
    end else begin
      if (commit) begin
        retireCntQ <= retireCntQ + 1'b1;
      end
      if (dropEv) begin
        overflowQ <= 1'b1;
        if (dropCntQ != '1) begin
          dropCntQ <= dropCntQ + 1'b1;
        end
      end
    end
  end

`ifdef COMMIT_FLOW_CHECK_EN
  logic        expValid;
  logic [63:0] expPc;
  logic        flowErrQ;
  logic [63:0] errPcQ;

  // Continuity check. It also sees dropped commits. Only the first
  // offending pc is latched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      expValid <= 1'b0;
      expPc    <= '0;
      flowErrQ <= 1'b0;
      errPcQ   <= '0;
    end else if (clr) begin
      expValid <= 1'b0;
      expPc    <= '0;
      flowErrQ <= 1'b0;
      errPcQ   <= '0;
    end else if (commit) begin
      if (expValid && (commit_pc != expPc)) begin
        flowErrQ <= 1'b1;
        if (!flowErrQ) begin
          errPcQ <= commit_pc;
        end
      end
      expPc    <= commit_pre_pc;
      expValid <= 1'b1;
    end
  end

  assign flow_err = flowErrQ;
  assign err_pc   = errPcQ;
`else
  assign flow_err = 1'b0;
  assign err_pc   = '0;
`endif

  assign trace_valid  = !isEmpty;
  assign trace_pc     = isEmpty ? '0 : pcMem[rdPtr];
  assign trace_pre_pc = isEmpty ? '0 : prePcMem[rdPtr];
  assign trace_instr  = isEmpty ? '0 : instrMem[rdPtr];
  assign level        = levelQ;
  assign overflow     = overflowQ;
  assign drop_cnt     = dropCntQ;
  assign retire_cnt   = retireCntQ;

endmodule

// File: tb/tb_commit_trace_fifo.sv
// Directed bench for commit_trace_fifo (DEPTH=16, CNT_W=32).
// Inputs are driven 1 ns after each rising edge. Outputs are sampled at
// that same point, before any new input takes effect at the next edge.
module tb_commit_trace_fifo;

  logic        clk;
  logic        rst;
  logic        clr;
  logic        commit;
  logic [63:0] commit_pc;
  logic [63:0] commit_pre_pc;
  logic [31:0] commit_instr;
  logic        trace_valid;
  logic        trace_ready;
  logic [63:0] trace_pc;
  logic [63:0] trace_pre_pc;
  logic [31:0] trace_instr;
  logic [4:0]  level;
  logic        overflow;
  logic [31:0] drop_cnt;
  logic [31:0] retire_cnt;
  logic        flow_err;
  logic [63:0] err_pc;

  int nVec  = 0;
  int nMiss = 0;

  commit_trace_fifo #(.DEPTH(16), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .commit(commit), .commit_pc(commit_pc), .commit_pre_pc(commit_pre_pc),
    .commit_instr(commit_instr),
    .trace_valid(trace_valid), .trace_ready(trace_ready),
    .trace_pc(trace_pc), .trace_pre_pc(trace_pre_pc), .trace_instr(trace_instr),
    .level(level), .overflow(overflow), .drop_cnt(drop_cnt),
    .retire_cnt(retire_cnt), .flow_err(flow_err), .err_pc(err_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nVec++;
    if (got !== exp) begin
      nMiss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic c, input logic [63:0] pc, input logic [63:0] pre, input logic [31:0] ins);
    commit        = c;
    commit_pc     = pc;
    commit_pre_pc = pre;
    commit_instr  = ins;
  endtask

  task automatic doClr();
    clr = 1'b1;
    drive(1'b0, 64'h0, 64'h0, 32'h0);
    tick();
    clr = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    clr = 1'b0;
    trace_ready = 1'b0;
    drive(1'b0, 64'h0, 64'h0, 32'h0);
    #2;
    checkVal("rst_valid", trace_valid, 0);
    checkVal("rst_level", level, 0);
    checkVal("rst_ovf", overflow, 0);
    checkVal("rst_drop", drop_cnt, 0);
    checkVal("rst_retire", retire_cnt, 0);
    checkVal("rst_ferr", flow_err, 0);
    checkVal("rst_errpc", err_pc, 0);
    checkVal("rst_tpc", trace_pc, 0);
    tick();
    rst = 1'b1;
    tick();

    // Three sequential commits, each visible one cycle later, with the host always ready.
    trace_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 64'h8000_0000 + 64'(4 * i), 64'h8000_0004 + 64'(4 * i), 32'h0000_0013 + 32'(i));
      tick();
      checkVal("t1_valid", trace_valid, 1);
      checkVal("t1_pc", trace_pc, 64'h8000_0000 + 64'(4 * i));
      checkVal("t1_prepc", trace_pre_pc, 64'h8000_0004 + 64'(4 * i));
      checkVal("t1_instr", trace_instr, 32'h0000_0013 + 32'(i));
    end
    drive(1'b0, 64'h0, 64'h0, 32'h0);
    tick();
    checkVal("t1_level", level, 0);
    checkVal("t1_valid0", trace_valid, 0);
    checkVal("t1_retire", retire_cnt, 3);
    checkVal("t1_ferr", flow_err, 0);

    // Eighteen commits with the host stalled: sixteen are kept and two dropped.
    doClr();
    trace_ready = 1'b0;
    for (int i = 0; i < 18; i++) begin
      drive(1'b1, 64'h1000 + 64'(4 * i), 64'h1004 + 64'(4 * i), 32'hA000_0000 | 32'(i));
      tick();
    end
    drive(1'b0, 64'h0, 64'h0, 32'h0);
    checkVal("t2_level", level, 16);
    checkVal("t2_ovf", overflow, 1);
    checkVal("t2_drop", drop_cnt, 2);
    checkVal("t2_retire", retire_cnt, 18);
    checkVal("t2_head", trace_pc, 64'h1000);
    checkVal("t2_headins", trace_instr, 32'hA000_0000);

    // Full FIFO with a commit and a pop in the same cycle: no drop, oldest entry leaves.
    trace_ready = 1'b1;
    drive(1'b1, 64'h1048, 64'h104C, 32'hA000_0012);
    tick();
    drive(1'b0, 64'h0, 64'h0, 32'h0);
    trace_ready = 1'b0;
    checkVal("t3_level", level, 16);
    checkVal("t3_drop", drop_cnt, 2);
    checkVal("t3_head", trace_pc, 64'h1004);
    checkVal("t3_retire", retire_cnt, 19);
    tick();
    checkVal("t3_hold", trace_pc, 64'h1004);

    // Drain the FIFO and check entries come out in order.
    trace_ready = 1'b1;
    for (int i = 1; i < 17; i++) begin
      if (i < 16) begin
        checkVal("t2_drain", trace_pc, 64'h1000 + 64'(4 * i));
        checkVal("t2_drainins", trace_instr, 32'hA000_0000 | 32'(i));
      end else begin
        checkVal("t3_drain", trace_pc, 64'h1048);
      end
      tick();
    end
    checkVal("t2_empty", trace_valid, 0);
    checkVal("t2_lvl0", level, 0);

    // Continuity checker: the second commit breaks the expected flow.
    doClr();
    drive(1'b1, 64'h8000_0000, 64'h8000_0010, 32'h13);
    tick();
    drive(1'b1, 64'h8000_0004, 64'h8000_0008, 32'h13);
    tick();
`ifdef COMMIT_FLOW_CHECK_EN
    checkVal("t4_ferr", flow_err, 1);
    checkVal("t4_errpc", err_pc, 64'h8000_0004);
`else
    checkVal("t4_ferr", flow_err, 0);
    checkVal("t4_errpc", err_pc, 0);
`endif
    drive(1'b1, 64'h9000_0000, 64'h9000_0004, 32'h13);
    tick();
    drive(1'b0, 64'h0, 64'h0, 32'h0);
`ifdef COMMIT_FLOW_CHECK_EN
    checkVal("t4_ferr2", flow_err, 1);
    checkVal("t4_errpc2", err_pc, 64'h8000_0004);
`else
    checkVal("t4_ferr2", flow_err, 0);
    checkVal("t4_errpc2", err_pc, 0);
`endif
    tick();

    // A clr takes priority over a simultaneous commit and also forgets the expected pc.
    doClr();
    trace_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 64'h2000 + 64'(4 * i), 64'h2004 + 64'(4 * i), 32'h13);
      tick();
    end
    checkVal("t5_level5", level, 5);
    clr = 1'b1;
    drive(1'b1, 64'h5555, 64'h5559, 32'h13);
    tick();
    clr = 1'b0;
    drive(1'b0, 64'h0, 64'h0, 32'h0);
    checkVal("t5_level", level, 0);
    checkVal("t5_valid", trace_valid, 0);
    checkVal("t5_retire", retire_cnt, 0);
    checkVal("t5_drop", drop_cnt, 0);
    checkVal("t5_ovf", overflow, 0);
    drive(1'b1, 64'h7777, 64'h777B, 32'h13);
    tick();
    drive(1'b0, 64'h0, 64'h0, 32'h0);
    checkVal("t5_ferr", flow_err, 0);
    checkVal("t5_level1", level, 1);
    checkVal("t5_retire1", retire_cnt, 1);

    // An asynchronous reset pulse in the middle of draining the FIFO.
    doClr();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 64'h3000 + 64'(4 * i), 64'h3004 + 64'(4 * i), 32'h13);
      tick();
    end
    drive(1'b0, 64'h0, 64'h0, 32'h0);
    trace_ready = 1'b1;
    tick();
    checkVal("t6_level", level, 3);
    #2;
    rst = 1'b0;
    #1;
    checkVal("t6_valid", trace_valid, 0);
    checkVal("t6_lvl", level, 0);
    checkVal("t6_tpc", trace_pc, 0);
    checkVal("t6_retire", retire_cnt, 0);
    #1;
    rst = 1'b1;
    tick();
    checkVal("t6_stay", level, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
    $finish;
  end

endmodule

// File: doc/commit_trace_fifo.md
# commit_trace_fifo

- Consumer end of the CPU commit stream (`commit`, `commit_pc`, `commit_pre_pc`, `commit_instr`) driven by the writeback stage.
- Captures each retired instruction into a show-ahead FIFO and drains it to a host/trace port over a valid/ready handshake.
- Tracks retired-instruction count, overflow drops and, optionally, control-flow continuity between successive commits.
- Sits beside the core top level and observes only; it never back-pressures the core.

## Interface
Parameters:
- DEPTH, 16, FIFO entries; power of two, ≥2.
- CNT_W, 32, width of the retire and drop counters.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous clear of FIFO, counters, flags and expected-pc state.
- commit  in  1  one instruction retires this cycle.
- commit_pc  in  64  pc of the retiring instruction.
- commit_pre_pc  in  64  next pc the core took after this instruction.
- commit_instr  in  32  instruction word.
- trace_valid  out  1  FIFO head entry is valid.
- trace_ready  in  1  host accepts the head entry.
- trace_pc  out  64  head entry pc.
- trace_pre_pc  out  64  head entry next pc.
- trace_instr  out  32  head entry instruction.
- level  out  $clog2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky; a commit was dropped because the FIFO was full.
- drop_cnt  out  CNT_W  number of dropped commits; saturates at all-ones.
- retire_cnt  out  CNT_W  number of commits seen, dropped or not; wraps modulo 2^CNT_W.
- flow_err  out  1  sticky continuity error (only with COMMIT_FLOW_CHECK_EN).
- err_pc  out  64  `commit_pc` of the first offending commit.

## Operation
- Push condition is `commit`; pop condition is `trace_valid && trace_ready`.
- A push while full is dropped: set `overflow` and increment `drop_cnt`.
  - Exception: a push with a simultaneous pop while full is accepted, and `level` stays at DEPTH.
- Pop while empty is ignored.
- Write and read pointers are log2(DEPTH) bits and wrap naturally. `level` is the full/empty discriminator.
- `retire_cnt` increments on every `commit`, independent of FIFO state.
- `clr` has priority over push and pop in the same cycle. It empties the FIFO, zeroes counters and flags, and invalidates the expected pc.
- Continuity check state is `exp_valid` and `exp_pc`:
  - On each `commit`, if `exp_valid` and `commit_pc != exp_pc`: set `flow_err`. If `flow_err` was 0, also capture `err_pc <= commit_pc`.
  - Then `exp_pc <= commit_pre_pc` and `exp_valid <= 1`.
  - The check runs on dropped commits as well.
- The first commit after reset or `clr` is never flagged.

## Timing
- Reset values:
  - `trace_valid`=0, `level`=0, `overflow`=0, `drop_cnt`=0, `retire_cnt`=0, `flow_err`=0, `err_pc`=0.
  - `trace_pc`, `trace_pre_pc`, `trace_instr` = 0 while empty.
  - Pointers 0, `exp_valid`=0.
- Latency:
  - A commit in cycle N is visible at the head, with `trace_valid`=1, in cycle N+1.
  - There is no same-cycle bypass when empty.
- Head data is held stable while `trace_valid && !trace_ready`.
- After a pop in cycle N, the next entry (or empty) appears in cycle N+1.
- Back-to-back commits every cycle with `trace_ready`=1 sustain full throughput, with no drops at any depth.
- `flow_err`, `err_pc`, `overflow` and counters update at the clock edge ending the commit cycle.
- Reset assertion mid-operation clears all state immediately (asynchronously). Entries in flight are lost.

## Configuration
- COMMIT_FLOW_CHECK_EN defined: the continuity checker, `exp_pc`/`exp_valid` and the `err_pc` capture are built.
- Undefined: checker logic is omitted; `flow_err` is tied 0 and `err_pc` is tied 0. Ports remain present.

## Test plan
- Reset, then 3 commits with pcs 0x80000000, 0x80000004, 0x80000008 (`pre_pc` = pc+4), `trace_ready`=1:
  - Head shows each entry one cycle after its commit.
  - `retire_cnt`=3, `level` back to 0, `flow_err`=0.
- `trace_ready`=0, 18 commits into DEPTH=16:
  - `level`=16, `overflow`=1, `drop_cnt`=2, `retire_cnt`=18.
  - Draining yields the first 16 entries in order.
- FIFO full, `commit` and `trace_ready` both high for one cycle:
  - `level` stays 16, no drop, and the oldest entry is popped.
- Flow check (macro defined): commit pc 0x80000000 with `pre_pc` 0x80000010, then commit pc 0x80000004:
  - `flow_err`=1, `err_pc`=0x80000004.
  - A later mismatch leaves `err_pc` unchanged.
  - Repeat with the macro undefined: `flow_err` stays 0.
- 5 entries queued, then `clr` with a simultaneous commit:
  - Next cycle `level`=0, `trace_valid`=0, counters 0.
  - The following commit is not flagged.
- Pulse `rst` low mid-drain: all outputs return to reset values asynchronously, before the next clock edge.
